// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags.
// Sits directly downstream of the ROB. Issue marks a destination busy on a ROB entry.
// Commit writes retired values back. Two source reads return either a value
// or the ROB entry that will produce it. Completed results still in the ROB are
// forwarded through the ready/value query ports.
module rename_reg_file #(
  parameter int unsigned ROB_BIT = 4,
  parameter int unsigned REG_NUM = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_up,

  // ROB issue port
  input  logic               issue_pollute,
  input  logic [4:0]         issue_reg_id,
  input  logic [ROB_BIT-1:0] issue_rob_entry,

  // ROB commit port
  input  logic               rob_commit,
  input  logic [4:0]         commit_rd_reg_id,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [31:0]        commit_value,

  // Decoder source indices
  input  logic [4:0]         rs1_id,
  input  logic [4:0]         rs2_id,

  // ROB query for pending sources
  output logic [ROB_BIT-1:0] get_rob_entry1,
  output logic [ROB_BIT-1:0] get_rob_entry2,
  input  logic               ready1,
  input  logic               ready2,
  input  logic [31:0]        value1,
  input  logic [31:0]        value2,

  // Operand results
  output logic               rs1_ready,
  output logic [31:0]        rs1_val,
  output logic [ROB_BIT-1:0] rs1_rob_entry,
  output logic               rs2_ready,
  output logic [31:0]        rs2_val,
  output logic [ROB_BIT-1:0] rs2_rob_entry
);

  typedef struct packed {
    logic               ready;
    logic [31:0]        val;
    logic [ROB_BIT-1:0] entry;
  } operand_t;

  logic [31:0]        val_q [REG_NUM];
  logic [31:0]        val_d [REG_NUM];
  logic [ROB_BIT-1:0] tag_q [REG_NUM];
  logic [ROB_BIT-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  logic               commit_en;
  logic               issue_en;

  // Writes to x0 are ignored, so x0 never becomes busy and keeps its zero value.
  assign commit_en = rob_commit && (commit_rd_reg_id != 5'd0);
  assign issue_en  = issue_pollute && (issue_reg_id != 5'd0);

  // Next state: commit first, then issue or flush overrides busy/tag.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;

    if (commit_en) begin
      val_d[commit_rd_reg_id] = commit_value;
      // A younger rename of the same register keeps it busy.
      if (tag_q[commit_rd_reg_id] == commit_rob_entry) begin
        busy_d[commit_rd_reg_id] = 1'b0;
      end
    end

    if (clear_up) begin
      // Flush drops every rename, including one issued this cycle.
      busy_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
        tag_d[i] = '0;
      end
    end else if (issue_en) begin
      busy_d[issue_reg_id] = 1'b1;
      tag_d[issue_reg_id]  = issue_rob_entry;
    end
  end

  // State registers; frozen while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Resolve one source operand from pre-issue state, the commit port and the ROB.
  function automatic operand_t resolve(
    input logic [4:0]         id,
    input logic               busy,
    input logic [ROB_BIT-1:0] tag,
    input logic [31:0]        val,
    input logic               rob_ready,
    input logic [31:0]        rob_value
  );
    operand_t res;
    res = '{ready: 1'b1, val: 32'd0, entry: '0};
    if (id == 5'd0) begin
      res.ready = 1'b1;
    end else if (!busy) begin
      res.val = val;
    end else if (rob_commit && (commit_rd_reg_id == id) && (commit_rob_entry == tag)) begin
      // Producer retires this very cycle.
      res.val = commit_value;
    end else if (rob_ready) begin
      // Producer has finished but not yet retired.
      res.val = rob_value;
    end else begin
      res.ready = 1'b0;
      res.entry = tag;
    end
    return res;
  endfunction

  logic               rs1_busy;
  logic               rs2_busy;
  operand_t           op1;
  operand_t           op2;

  // ROB query tags, zero when the source is not renamed.
  always_comb begin
    rs1_busy       = busy_q[rs1_id];
    rs2_busy       = busy_q[rs2_id];
    get_rob_entry1 = rs1_busy ? tag_q[rs1_id] : '0;
    get_rob_entry2 = rs2_busy ? tag_q[rs2_id] : '0;
  end

  // Operand read for both sources.
  always_comb begin
    op1 = resolve(rs1_id, rs1_busy, tag_q[rs1_id], val_q[rs1_id], ready1, value1);
    op2 = resolve(rs2_id, rs2_busy, tag_q[rs2_id], val_q[rs2_id], ready2, value2);

    rs1_ready     = op1.ready;
    rs1_val       = op1.val;
    rs1_rob_entry = op1.entry;
    rs2_ready     = op2.ready;
    rs2_val       = op2.val;
    rs2_rob_entry = op2.entry;
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file with hand-computed expectations.
module tb_rename_reg_file;

  localparam int unsigned ROB_BIT = 4;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               rdy_in;
  logic               clear_up;
  logic               issue_pollute;
  logic [4:0]         issue_reg_id;
  logic [ROB_BIT-1:0] issue_rob_entry;
  logic               rob_commit;
  logic [4:0]         commit_rd_reg_id;
  logic [ROB_BIT-1:0] commit_rob_entry;
  logic [31:0]        commit_value;
  logic [4:0]         rs1_id;
  logic [4:0]         rs2_id;
  logic [ROB_BIT-1:0] get_rob_entry1;
  logic [ROB_BIT-1:0] get_rob_entry2;
  logic               ready1;
  logic               ready2;
  logic [31:0]        value1;
  logic [31:0]        value2;
  logic               rs1_ready;
  logic [31:0]        rs1_val;
  logic [ROB_BIT-1:0] rs1_rob_entry;
  logic               rs2_ready;
  logic [31:0]        rs2_val;
  logic [ROB_BIT-1:0] rs2_rob_entry;

  int n_cmp = 0;
  int n_err = 0;

  rename_reg_file #(
    .ROB_BIT(ROB_BIT),
    .REG_NUM(32)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clear_up         (clear_up),
    .issue_pollute    (issue_pollute),
    .issue_reg_id     (issue_reg_id),
    .issue_rob_entry  (issue_rob_entry),
    .rob_commit       (rob_commit),
    .commit_rd_reg_id (commit_rd_reg_id),
    .commit_rob_entry (commit_rob_entry),
    .commit_value     (commit_value),
    .rs1_id           (rs1_id),
    .rs2_id           (rs2_id),
    .get_rob_entry1   (get_rob_entry1),
    .get_rob_entry2   (get_rob_entry2),
    .ready1           (ready1),
    .ready2           (ready2),
    .value1           (value1),
    .value2           (value2),
    .rs1_ready        (rs1_ready),
    .rs1_val          (rs1_val),
    .rs1_rob_entry    (rs1_rob_entry),
    .rs2_ready        (rs2_ready),
    .rs2_val          (rs2_val),
    .rs2_rob_entry    (rs2_rob_entry)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [ROB_BIT-1:0] entry);
    issue_pollute   = 1'b1;
    issue_reg_id    = rd;
    issue_rob_entry = entry;
    tick();
    issue_pollute   = 1'b0;
  endtask

  task automatic set_commit(input logic [4:0] rd, input logic [ROB_BIT-1:0] entry,
                            input logic [31:0] value);
    rob_commit       = 1'b1;
    commit_rd_reg_id = rd;
    commit_rob_entry = entry;
    commit_value     = value;
  endtask

  initial begin
    rst_in = 1'b1;  rdy_in = 1'b1;  clear_up = 1'b0;
    issue_pollute = 1'b0;  issue_reg_id = '0;  issue_rob_entry = '0;
    rob_commit = 1'b0;  commit_rd_reg_id = '0;  commit_rob_entry = '0;  commit_value = '0;
    rs1_id = 5'd5;  rs2_id = 5'd0;
    ready1 = 1'b0;  ready2 = 1'b0;  value1 = '0;  value2 = '0;

    // Reset state
    #1;
    check("rst_rs1_ready", 32'(rs1_ready), 32'd1);
    check("rst_rs1_val", rs1_val, 32'd0);
    check("rst_rs1_entry", 32'(rs1_rob_entry), 32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // Rename x5 to entry 3; pending read
    issue(5'd5, 4'd3);
    rs1_id = 5'd5;
    #1;
    check("pend_rs1_ready", 32'(rs1_ready), 32'd0);
    check("pend_rs1_entry", 32'(rs1_rob_entry), 32'd3);
    check("pend_get_entry1", 32'(get_rob_entry1), 32'd3);
    check("pend_rs1_val", rs1_val, 32'd0);

    // ROB forward, no state change
    ready1 = 1'b1;  value1 = 32'h1234;
    #1;
    check("fwd_rs1_ready", 32'(rs1_ready), 32'd1);
    check("fwd_rs1_val", rs1_val, 32'h1234);
    check("fwd_rs1_entry", 32'(rs1_rob_entry), 32'd0);
    ready1 = 1'b0;  value1 = '0;
    #1;
    check("nofwd_rs1_ready", 32'(rs1_ready), 32'd0);

    // Commit bypass then architectural read
    set_commit(5'd5, 4'd3, 32'h1234);
    #1;
    check("byp_rs1_ready", 32'(rs1_ready), 32'd1);
    check("byp_rs1_val", rs1_val, 32'h1234);
    tick();
    rob_commit = 1'b0;
    rs2_id = 5'd5;
    #1;
    check("arch_rs1_ready", 32'(rs1_ready), 32'd1);
    check("arch_rs1_val", rs1_val, 32'h1234);
    check("arch_get_entry1", 32'(get_rob_entry1), 32'd0);
    check("arch_rs2_val", rs2_val, 32'h1234);

    // Double rename of x7; stale commit writes value but keeps busy
    issue(5'd7, 4'd2);
    issue(5'd7, 4'd6);
    rs2_id = 5'd7;
    set_commit(5'd7, 4'd2, 32'd9);
    #1;
    check("stale_byp_rs2_ready", 32'(rs2_ready), 32'd0);
    tick();
    rob_commit = 1'b0;
    #1;
    check("stale_rs2_ready", 32'(rs2_ready), 32'd0);
    check("stale_rs2_entry", 32'(rs2_rob_entry), 32'd6);
    check("stale_get_entry2", 32'(get_rob_entry2), 32'd6);

    // Same-cycle commit and issue on x8
    set_commit(5'd8, 4'd4, 32'h88);
    issue(5'd8, 4'd9);
    rob_commit = 1'b0;
    rs1_id = 5'd8;
    #1;
    check("ci_rs1_ready", 32'(rs1_ready), 32'd0);
    check("ci_rs1_entry", 32'(rs1_rob_entry), 32'd9);

    // Read sees pre-issue mapping while x8 is being re-renamed
    issue_pollute = 1'b1;  issue_reg_id = 5'd8;  issue_rob_entry = 4'd11;
    #1;
    check("self_rs1_entry", 32'(rs1_rob_entry), 32'd9);
    issue_pollute = 1'b0;

    // ROB forward on source 2
    issue(5'd11, 4'd7);
    rs2_id = 5'd11;  ready2 = 1'b1;  value2 = 32'habc;
    #1;
    check("fwd2_rs2_ready", 32'(rs2_ready), 32'd1);
    check("fwd2_rs2_val", rs2_val, 32'habc);
    ready2 = 1'b0;  value2 = '0;

    // Flush with same-cycle issue
    issue(5'd3, 4'd1);
    clear_up = 1'b1;
    issue(5'd4, 4'd5);
    clear_up = 1'b0;
    rs1_id = 5'd3;  rs2_id = 5'd4;
    #1;
    check("fl_rs1_ready", 32'(rs1_ready), 32'd1);
    check("fl_rs2_ready", 32'(rs2_ready), 32'd1);
    check("fl_get_entry2", 32'(get_rob_entry2), 32'd0);
    rs1_id = 5'd7;  rs2_id = 5'd8;
    #1;
    check("fl_x7_ready", 32'(rs1_ready), 32'd1);
    check("fl_x7_val", rs1_val, 32'd9);
    check("fl_x8_ready", 32'(rs2_ready), 32'd1);
    check("fl_x8_val", rs2_val, 32'h88);

    // Frozen while rdy_in is low
    rdy_in = 1'b0;
    set_commit(5'd7, 4'd0, 32'h77);
    issue(5'd10, 4'd2);
    rob_commit = 1'b0;
    rdy_in = 1'b1;
    rs1_id = 5'd10;  rs2_id = 5'd7;
    #1;
    check("frz_rs1_ready", 32'(rs1_ready), 32'd1);
    check("frz_x7_val", rs2_val, 32'd9);

    // x0 ignores issue and commit
    set_commit(5'd0, 4'd3, 32'hdead);
    issue(5'd0, 4'd3);
    rob_commit = 1'b0;
    rs1_id = 5'd0;
    #1;
    check("x0_ready", 32'(rs1_ready), 32'd1);
    check("x0_val", rs1_val, 32'd0);
    check("x0_get_entry1", 32'(get_rob_entry1), 32'd0);

    // Reset mid-run clears busy and values
    issue(5'd5, 4'd12);
    rs1_id = 5'd5;
    #1;
    check("pre_rst_rs1_ready", 32'(rs1_ready), 32'd0);
    rst_in = 1'b1;
    #1;
    check("mid_rst_rs1_ready", 32'(rs1_ready), 32'd1);
    check("mid_rst_rs1_val", rs1_val, 32'd0);
    check("mid_rst_x7_val", rs2_val, 32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
